// File: rtl/jk_pkg.sv
// Shared constants for the JK-based sequential library: excitation codes {J,K}
// and the default counter width.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter built from JK cells: per-bit J/K excitation from
// load/count controls, plus a combinational terminal-count output for cascading.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH:0]        up_carry;
    logic [WIDTH:0]        dn_carry;
    logic [WIDTH-1:0][1:0] jk;

    // up_carry[i] = AND of q[i-1:0]; dn_carry[i] = AND of ~q[i-1:0].
    // Index WIDTH doubles as the all-ones / all-zeros detector for tc.
    always_comb begin
        up_carry    = '0;
        dn_carry    = '0;
        up_carry[0] = 1'b1;
        dn_carry[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_carry[i+1] = up_carry[i] & q[i];
            dn_carry[i+1] = dn_carry[i] & ~q[i];
        end
    end

    always_comb begin
        jk = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (load) begin
                jk[i] = din[i] ? JK_SET : JK_RST;
            end else if (en) begin
                jk[i] = (up ? up_carry[i] : dn_carry[i]) ? JK_TGL : JK_HOLD;
            end else begin
                jk[i] = JK_HOLD;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (jk[g][1]),
            .k   (jk[g][0]),
            .q   (q[g])
        );
    end

    assign tc = en & ~load & ((up & up_carry[WIDTH]) | (~up & dn_carry[WIDTH]));

endmodule
